fdc_disk_server: RTL

Disk-side back end of the NEC765 FDC. It decodes the FDC's `disk_sr` command word (seek, read sector, write sector, read ID) and maps CHRS to a linear block address. It moves 512-byte sectors between a byte-streaming block-device port and the FDC's sector FIFOs. Completion and error status return on `disk_cr`.

---
 rtl/fdc_disk_pkg.sv | 36 +++
 rtl/fdc_lba_calc.sv | 31 +++
 rtl/fdc_disk_server.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fdc_disk_pkg.sv
// rtl/fdc_disk_pkg.sv - shared constants, state enum and helpers for the FDC disk server
package fdc_disk_pkg;

  // disk_sr field positions
  localparam int SR_TRK_LSB  = 8;
  localparam int SR_HEAD     = 15;
  localparam int SR_ACK      = 16;
  localparam int SR_RD_LSB   = 17;
  localparam int SR_WR_LSB   = 20;
  localparam int SR_RID_LSB  = 22;
  localparam int SR_SEEK_LSB = 24;

  // disk_cr field positions
  localparam int CR_SEC_LSB  = 24;
  localparam int CR_RDY_LSB  = 5;
  localparam int CR_DONE     = 4;
  localparam int CR_ERR      = 3;

  localparam int SECTOR_BYTES = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_READID,
    ST_LOOKUP,
    ST_BLK_RD,
    ST_BLK_WR,
    ST_ACKWAIT
  } state_e;

  // One-hot drive select to drive index; 2'b10 is drive 1, anything else drive 0.
  function automatic logic drive_idx(input logic [1:0] sel);
    return sel[1] & ~sel[0];
  endfunction

endpackage

// File: rtl/fdc_lba_calc.sv
// rtl/fdc_lba_calc.sv - combinational CHRS to linear block address with range check
// Ports: sector/track/head/drive/mounted in; lba (32 bit) and range_err out.
module fdc_lba_calc
  import fdc_disk_pkg::*;
#(
  parameter int SECTOR_BASE = 8'hC1,
  parameter int SPT         = 9,
  parameter int SIDES       = 1,
  parameter int MAX_TRACKS  = 40
) (
  input  logic [7:0]  sector,
  input  logic [6:0]  track,
  input  logic        head,
  input  logic        drive,
  input  logic        mounted,
  output logic [31:0] lba,
  output logic        range_err
);

  always_comb begin
    lba = 32'(drive) * 32'(MAX_TRACKS * SIDES * SPT)
        + (32'(track) * 32'(SIDES) + 32'(head)) * 32'(SPT)
        + 32'(sector) - 32'(SECTOR_BASE);
    range_err = (32'(sector) <  32'(SECTOR_BASE))
              | (32'(sector) >= 32'(SECTOR_BASE + SPT))
              | (32'(track)  >= 32'(MAX_TRACKS))
              | (32'(head)   >= 32'(SIDES))
              | ~mounted;
  end

endmodule

// File: rtl/fdc_disk_server.sv
// rtl/fdc_disk_server.sv - NEC765 disk-side back end: command decode, LBA mapping, sector moves
// Ports: clk/rst_n; disk_sr command in, disk_cr status out; FDC FIFO byte ports
// (disk_data_in/clkin, disk_data_out/clkout); img_mounted; block-device port blk_*.
// Optional: DSKSRV_READID_ROTATE_EN makes READID report a rotating sector index.
module fdc_disk_server
  import fdc_disk_pkg::*;
#(
  parameter int SECTOR_BASE = 8'hC1,
  parameter int SPT         = 9,
  parameter int SIDES       = 1,
  parameter int MAX_TRACKS  = 40,
  parameter int FIFO_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] disk_sr,
  output logic [31:0] disk_cr,
  output logic [7:0]  disk_data_in,
  output logic        disk_data_clkin,
  input  logic [7:0]  disk_data_out,
  output logic        disk_data_clkout,
  input  logic [1:0]  img_mounted,
  output logic        blk_req,
  output logic        blk_we,
  output logic [31:0] blk_lba,
  input  logic [7:0]  blk_rdata,
  input  logic        blk_rvalid,
  output logic [7:0]  blk_wdata,
  output logic        blk_wvalid,
  input  logic        blk_wready,
  input  logic        blk_done,
  input  logic        blk_err
);

  state_e      state_q, state_d;
  logic [7:0]  sec_q, sec_d, cr_sec_q, cr_sec_d, rd_data_q, rd_data_d, wdata_q, wdata_d;
  logic [6:0]  trk_q, trk_d;
  logic        head_q, head_d, drv_q, drv_d, is_wr_q, is_wr_d;
  logic [31:0] lba_q, lba_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        full_q, full_d;
  logic        clkin_q, clkin_d, clkout_q, clkout_d;
  logic        wvalid_q, wvalid_d, wpend_q, wpend_d;
  logic [3:0]  wlat_q, wlat_d;
  logic [1:0]  rdy_q, rdy_d, seek_done_q, seek_done_d;
  logic        done_q, done_d, err_q, err_d;

  logic [1:0]  sk_sel, rid_sel, rd_sel, wr_sel, cmd_sel;
  logic        ack, any_cmd;
  logic [31:0] lba_calc;
  logic        range_err;
  logic [7:0]  rot_idx;
  logic        unused_sr;

  assign sk_sel    = disk_sr[SR_SEEK_LSB +: 2];
  assign rid_sel   = disk_sr[SR_RID_LSB +: 2];
  assign rd_sel    = disk_sr[SR_RD_LSB +: 2];
  assign wr_sel    = disk_sr[SR_WR_LSB +: 2];
  assign ack       = disk_sr[SR_ACK];
  assign any_cmd   = |{sk_sel, rid_sel, rd_sel, wr_sel};
  assign unused_sr = ^{disk_sr[31:26], disk_sr[19]};
  // Seek > read ID > read > write
  assign cmd_sel   = (sk_sel != 2'b00) ? sk_sel : (rid_sel != 2'b00) ? rid_sel :
                     (rd_sel != 2'b00) ? rd_sel : wr_sel;

  fdc_lba_calc #(
    .SECTOR_BASE(SECTOR_BASE), .SPT(SPT), .SIDES(SIDES), .MAX_TRACKS(MAX_TRACKS)
  ) u_lba (
    .sector(sec_q), .track(trk_q), .head(head_q), .drive(drv_q),
    .mounted(img_mounted[drv_q]), .lba(lba_calc), .range_err(range_err)
  );

`ifdef DSKSRV_READID_ROTATE_EN
  logic [15:0] rot_tick_q, rot_tick_d;
  logic [7:0]  rot_q, rot_d;
  always_comb begin
    rot_tick_d = rot_tick_q + 16'd1;
    rot_d      = rot_q;
    if (rot_tick_q == 16'hFFFF) rot_d = (rot_q == 8'(SPT - 1)) ? 8'd0 : rot_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rot_tick_q <= '0;
      rot_q      <= '0;
    end else begin
      rot_tick_q <= rot_tick_d;
      rot_q      <= rot_d;
    end
  end
  assign rot_idx = rot_q;
`else
  assign rot_idx = 8'd0;
`endif

  always_comb begin
    state_d = state_q;  sec_d = sec_q;  trk_d = trk_q;  head_d = head_q;  drv_d = drv_q;
    is_wr_d = is_wr_q;  lba_d = lba_q;  cnt_d = cnt_q;  full_d = full_q;
    rd_data_d = rd_data_q;  wdata_d = wdata_q;  wvalid_d = wvalid_q;  wpend_d = wpend_q;
    wlat_d = wlat_q;  cr_sec_d = cr_sec_q;  seek_done_d = seek_done_q;
    done_d = done_q;  err_d = err_q;
    clkin_d = 1'b0;  clkout_d = 1'b0;
    rdy_d = img_mounted;

    case (state_q)
      ST_IDLE: begin
        if (any_cmd) begin
          sec_d  = disk_sr[7:0];
          trk_d  = disk_sr[SR_TRK_LSB +: 7];
          head_d = disk_sr[SR_HEAD];
          drv_d  = drive_idx(cmd_sel);
          is_wr_d = (sk_sel == 2'b00) && (rid_sel == 2'b00) && (rd_sel == 2'b00);
          if (sk_sel != 2'b00)       state_d = ST_SEEK;
          else if (rid_sel != 2'b00) state_d = ST_READID;
          else                       state_d = ST_LOOKUP;
        end
      end
      ST_SEEK: begin
        seek_done_d[drv_q] = 1'b1;
        err_d   = (32'(trk_q) >= 32'(MAX_TRACKS)) | ~img_mounted[drv_q];
        state_d = ST_ACKWAIT;
      end
      ST_READID: begin
        cr_sec_d = 8'(SECTOR_BASE) + rot_idx;
        done_d   = 1'b1;
        err_d    = ~img_mounted[drv_q];
        state_d  = ST_ACKWAIT;
      end
      ST_LOOKUP: begin
        cnt_d = '0;  full_d = 1'b0;  wvalid_d = 1'b0;  wpend_d = 1'b0;
        if (range_err) begin
          cr_sec_d = sec_q;
          done_d   = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_ACKWAIT;
        end else begin
          lba_d   = lba_calc;
          state_d = is_wr_q ? ST_BLK_WR : ST_BLK_RD;
        end
      end
      ST_BLK_RD: begin
        // Bytes beyond a full sector are silently dropped.
        if (blk_rvalid && !full_q) begin
          rd_data_d = blk_rdata;
          clkin_d   = 1'b1;
          cnt_d     = cnt_q + 9'd1;
          if (cnt_q == 9'(SECTOR_BYTES - 1)) full_d = 1'b1;
        end
      end
      ST_BLK_WR: begin
        // One byte in flight: pop, wait out FIFO latency, present until accepted.
        if (wvalid_q) begin
          if (blk_wready) begin
            wvalid_d = 1'b0;
            cnt_d    = cnt_q + 9'd1;
            if (cnt_q == 9'(SECTOR_BYTES - 1)) full_d = 1'b1;
          end
        end else if (wpend_q) begin
          if (wlat_q == 4'(FIFO_RD_LAT)) begin
            wdata_d  = disk_data_out;
            wvalid_d = 1'b1;
            wpend_d  = 1'b0;
          end else begin
            wlat_d = wlat_q + 4'd1;
          end
        end else if (!full_q) begin
          clkout_d = 1'b1;
          wpend_d  = 1'b1;
          wlat_d   = '0;
        end
      end
      ST_ACKWAIT: begin
        // Release on a clean ack, or on a fresh command issued without one.
        if ((ack && !any_cmd) || (!ack && any_cmd)) begin
          done_d      = 1'b0;
          err_d       = 1'b0;
          seek_done_d = 2'b00;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A short transfer (fewer than a full sector) reports as an error.
    if (blk_done && (state_q == ST_BLK_RD || state_q == ST_BLK_WR)) begin
      done_d   = 1'b1;
      err_d    = blk_err | ~full_d;
      cr_sec_d = sec_q;
      wvalid_d = 1'b0;
      wpend_d  = 1'b0;
      state_d  = ST_ACKWAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;  sec_q <= '0;  trk_q <= '0;  head_q <= 1'b0;  drv_q <= 1'b0;
      is_wr_q <= 1'b0;  lba_q <= '0;  cnt_q <= '0;  full_q <= 1'b0;
      rd_data_q <= '0;  wdata_q <= '0;  wvalid_q <= 1'b0;  wpend_q <= 1'b0;  wlat_q <= '0;
      clkin_q <= 1'b0;  clkout_q <= 1'b0;  cr_sec_q <= '0;  rdy_q <= '0;
      seek_done_q <= '0;  done_q <= 1'b0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  sec_q <= sec_d;  trk_q <= trk_d;  head_q <= head_d;  drv_q <= drv_d;
      is_wr_q <= is_wr_d;  lba_q <= lba_d;  cnt_q <= cnt_d;  full_q <= full_d;
      rd_data_q <= rd_data_d;  wdata_q <= wdata_d;  wvalid_q <= wvalid_d;  wpend_q <= wpend_d;
      wlat_q <= wlat_d;  clkin_q <= clkin_d;  clkout_q <= clkout_d;  cr_sec_q <= cr_sec_d;
      rdy_q <= rdy_d;  seek_done_q <= seek_done_d;  done_q <= done_d;  err_q <= err_d;
    end
  end

  assign disk_cr          = {cr_sec_q, 17'd0, rdy_q, done_q, err_q, 1'b0, seek_done_q};
  assign disk_data_in     = rd_data_q;
  assign disk_data_clkin  = clkin_q;
  assign disk_data_clkout = clkout_q;
  assign blk_req          = (state_q == ST_BLK_RD) || (state_q == ST_BLK_WR);
  assign blk_we           = (state_q == ST_BLK_WR);
  assign blk_lba          = lba_q;
  assign blk_wdata        = wdata_q;
  assign blk_wvalid       = wvalid_q;

endmodule
